spi_frame_loader: RTL and testbench
===================================

Name: spi_frame_loader

Overview:
- Generalised successor to the display SPI row loader.
- Consumes the byte stream from the SPI slave and assembles pixels of CHANNELS colour components × SEGMENTS panels. Issues write strobes into the back frame buffer.
- Adds: configurable channel count, extended addressing (row > 15, arbitrary start column), optional row auto-advance, protocol error counting and a busy flag.
- Sits between spi_slave and the frame buffer / flip logic.

Parameters:
- SEGMENTS, 1, number of chained panels per pixel word
- ROWS, 8, addressable rows (≥2)
- COLUMNS, 32, pixels per row (≥2)
- BITWIDTH, 8, bits per colour component (must be 8: one SPI byte per component)
- CHANNELS, 3, colour components per pixel per segment (1..4)
- WRAP_ROW, 0, 1 = row increments (mod ROWS) when column wraps

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  byte from spi_slave
- rx_valid  in  1  one-cycle strobe, rx_data valid
- ss  in  1  slave-select, 1 = transaction active
- ready  in  1  flip logic: front/back swap done (rising edge significant)
- wdata  out  SEGMENTS*CHANNELS*8  pixel word, oldest byte in MSBs
- wrow  out  $clog2(ROWS)  write row
- wcol  out  $clog2(COLUMNS)  write column
- wen  out  1  one-cycle write strobe
- loaded  out  1  one-cycle pulse: frame committed
- busy  out  1  1 while state ≠ IDLE
- err_count  out  8  saturating protocol-error count

Behaviour:
- Reset: all outputs 0; state IDLE; complete=0; last_ready=0; internal counters 0.
- Bytes with rx_valid=1 and ss=0 are ignored.
- IDLE, on rx_valid (first byte of transaction):
  - 0xF0|r with r<ROWS: row=r, col=0 → PIXEL.
  - 0x20 → HDR_ROW.
  - 0x10 → COMMIT.
  - 0x11: complete=0 → DRAIN.
  - anything else, or 0xFr with r≥ROWS: err_count++ → DRAIN.
- HDR_ROW: next byte = row. If ≥ROWS, err++ → DRAIN; else → HDR_COL.
- HDR_COL: next byte = start column. If ≥COLUMNS, err++ → DRAIN; else col=byte, byte counter=0 → PIXEL.
- PIXEL: each byte shifts wdata left 8 bits, new byte into LSBs; byte counter increments.
  - On the SEGMENTS*CHANNELS-th byte, in the next cycle: wen=1 (only if complete=0), wrow=row, wcol=col, wdata is the full word. Counter → 0.
  - col increments; col COLUMNS-1 wraps to 0. On wrap, row=(row+1) mod ROWS if WRAP_ROW=1, else row is unchanged.
  - Latency: one cycle from the final rx_valid to wen.
- ss=0 in PIXEL: → IDLE. If byte counter ≠ 0 (partial pixel), the partial is discarded and err++.
- COMMIT: further bytes ignored. On ss=0: → IDLE; loaded=1 for one cycle iff complete=0; complete=1; row=col=0; wrow=wcol=0.
- DRAIN: bytes ignored; ss=0 → IDLE.
- If ss=0 and rx_valid land in the same cycle: the byte is ignored and the ss=0 action is taken.
- complete=1 suppresses wen and loaded. Byte parsing continues.
- Ready edge: registered last_ready. A cycle with ready=1 and last_ready=0 clears complete.
  - If this coincides with a COMMIT ss=0 cycle, the commit wins: complete stays 1, loaded evaluated on the old complete.
- err_count saturates at 255; cleared only by rst.
- busy = (state ≠ IDLE), registered with the state.
- rst mid-transaction: immediate return to reset values. Bytes until the next ss low are treated as a new first byte.

Test Plan:
- CHANNELS=3, SEGMENTS=1: ss=1, send F2, then 6 bytes 01..06, ss=0 → wen twice; (row2,col0,0x010203), (row2,col1,0x040506); err_count=0.
- Send 20,05,1F + 3 bytes with ROWS=8, COLUMNS=32, WRAP_ROW=1 → wen at row5 col31, then 3 more bytes → row6 col0.
- Commit: 10 then ss=0 → loaded pulses once. Load F0 + 3 bytes → no wen. Pulse ready 0→1 → next F0 load produces wen.
- Second commit before a ready edge → no loaded pulse. Then ready edge coincident with a commit's ss=0 → complete stays 1.
- Invalid opcodes 0x55 and F9 (ROWS=8), and F0 + 2 bytes then ss=0 → err_count=3, no wen.
- Assert rst during PIXEL after 2 bytes → all outputs 0, busy=0. Next transaction F1 + 3 bytes writes row1 col0.

Source files
------------

// File: rtl/spi_frame_loader.sv
// SPI byte-stream to frame-buffer loader: parses row/column headers,
// packs colour bytes into pixel words and drives write/commit strobes.
module spi_frame_loader #(
   parameter int SEGMENTS = 1,
   parameter int ROWS     = 8,
   parameter int COLUMNS  = 32,
   parameter int BITWIDTH = 8,
   parameter int CHANNELS = 3,
   parameter int WRAP_ROW = 0
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [7:0]                             rx_data,
   input  logic                                   rx_valid,
   input  logic                                   ss,
   input  logic                                   ready,
   output logic [SEGMENTS*CHANNELS*BITWIDTH-1:0]  wdata,
   output logic [$clog2(ROWS)-1:0]                wrow,
   output logic [$clog2(COLUMNS)-1:0]             wcol,
   output logic                                   wen,
   output logic                                   loaded,
   output logic                                   busy,
   output logic [7:0]                             err_count
);

   localparam int NB = SEGMENTS * CHANNELS;
   localparam int WW = NB * BITWIDTH;
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLUMNS);
   localparam int BW = $clog2(NB + 1);
   localparam logic [31:0] ROWS_L = ROWS;
   localparam logic [31:0] COLS_L = COLUMNS;

   typedef enum logic [2:0] {
      IDLE, HDR_ROW, HDR_COL, PIXEL, COMMIT, DRAIN
   } state_t;

   state_t state, state_n;

   logic [RW-1:0] row;
   logic [CW-1:0] col;
   logic [BW-1:0] cnt;
   logic          complete;
   logic          last_ready;

   logic        byte_in, rdy_edge, last_byte;
   logic [31:0] byte_w;
   logic        op_pix, ld_row, ld_col, pix_byte;
   logic        pix_abort, commit, clr_cmp, err_inc;

   assign byte_in   = rx_valid & ss;
   assign byte_w    = {24'd0, rx_data};
   assign rdy_edge  = ready & ~last_ready;
   assign last_byte = (cnt == BW'(NB - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n   = state;
      op_pix    = 1'b0;
      ld_row    = 1'b0;
      ld_col    = 1'b0;
      pix_byte  = 1'b0;
      pix_abort = 1'b0;
      commit    = 1'b0;
      clr_cmp   = 1'b0;
      err_inc   = 1'b0;
      unique case (state)
         IDLE: begin
            if (byte_in) begin
               if (rx_data[7:4] == 4'hF &&
                   {28'd0, rx_data[3:0]} < ROWS_L) begin
                  op_pix  = 1'b1;
                  state_n = PIXEL;
               end else if (rx_data == 8'h20) begin
                  state_n = HDR_ROW;
               end else if (rx_data == 8'h10) begin
                  state_n = COMMIT;
               end else if (rx_data == 8'h11) begin
                  clr_cmp = 1'b1;
                  state_n = DRAIN;
               end else begin
                  err_inc = 1'b1;
                  state_n = DRAIN;
               end
            end
         end
         HDR_ROW: begin
            if (!ss) begin
               state_n = IDLE;
            end else if (rx_valid) begin
               if (byte_w < ROWS_L) begin
                  ld_row  = 1'b1;
                  state_n = HDR_COL;
               end else begin
                  err_inc = 1'b1;
                  state_n = DRAIN;
               end
            end
         end
         HDR_COL: begin
            if (!ss) begin
               state_n = IDLE;
            end else if (rx_valid) begin
               if (byte_w < COLS_L) begin
                  ld_col  = 1'b1;
                  state_n = PIXEL;
               end else begin
                  err_inc = 1'b1;
                  state_n = DRAIN;
               end
            end
         end
         PIXEL: begin
            if (!ss) begin
               state_n   = IDLE;
               pix_abort = (cnt != '0);
               err_inc   = (cnt != '0);
            end else if (rx_valid) begin
               pix_byte = 1'b1;
            end
         end
         COMMIT: begin
            if (!ss) begin
               commit  = 1'b1;
               state_n = IDLE;
            end
         end
         DRAIN: begin
            if (!ss) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row        <= '0;
         col        <= '0;
         cnt        <= '0;
         complete   <= 1'b0;
         last_ready <= 1'b0;
         wdata      <= '0;
         wrow       <= '0;
         wcol       <= '0;
         wen        <= 1'b0;
         loaded     <= 1'b0;
         busy       <= 1'b0;
         err_count  <= '0;
      end else begin
         wen        <= 1'b0;
         loaded     <= 1'b0;
         last_ready <= ready;
         busy       <= (state_n != IDLE);
         if (err_inc && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
         // a commit in the same cycle as a ready edge keeps the frame held
         if (commit) begin
            complete <= 1'b1;
            loaded   <= ~complete;
            row      <= '0;
            col      <= '0;
            wrow     <= '0;
            wcol     <= '0;
         end else if (clr_cmp || rdy_edge) begin
            complete <= 1'b0;
         end
         if (op_pix) begin
            row <= RW'(rx_data[3:0]);
            col <= '0;
            cnt <= '0;
         end
         if (ld_row) row <= RW'(rx_data);
         if (ld_col) begin
            col <= CW'(rx_data);
            cnt <= '0;
         end
         if (pix_abort) cnt <= '0;
         if (pix_byte) begin
            wdata <= (wdata << 8) | WW'(rx_data);
            if (last_byte) begin
               cnt  <= '0;
               wen  <= ~complete;
               wrow <= row;
               wcol <= col;
               if (col == CW'(COLUMNS - 1)) begin
                  col <= '0;
                  if (WRAP_ROW != 0)
                     row <= (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
               end else begin
                  col <= col + 1'b1;
               end
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_frame_loader.sv
// Directed bench for spi_frame_loader: scoreboarded pixel writes,
// commit/ready handshake, error counting and mid-transaction reset.
module tb_spi_frame_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        ss = 1'b0;
   logic        ready = 1'b0;
   logic [23:0] wdata;
   logic [2:0]  wrow;
   logic [4:0]  wcol;
   logic        wen, loaded, busy;
   logic [7:0]  err_count;

   int checks = 0;
   int errors = 0;
   int loaded_cnt = 0;
   int rd_idx = 0;
   logic prev_rxv = 1'b0;

   typedef struct packed {
      logic [2:0]  row;
      logic [4:0]  col;
      logic [23:0] data;
      logic        lat;
   } wr_t;

   wr_t exp_q[$];
   wr_t obs_q[$];

   always #5 clk = ~clk;

   spi_frame_loader #(
      .SEGMENTS(1), .ROWS(8), .COLUMNS(32),
      .BITWIDTH(8), .CHANNELS(3), .WRAP_ROW(1)
   ) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .ss(ss), .ready(ready), .wdata(wdata), .wrow(wrow), .wcol(wcol),
      .wen(wen), .loaded(loaded), .busy(busy), .err_count(err_count)
   );

   always @(posedge clk) prev_rxv <= rx_valid;

   always @(negedge clk) begin
      if (wen) obs_q.push_back('{wrow, wcol, wdata, prev_rxv});
      if (loaded) loaded_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic ss_on();
      @(negedge clk);
      ss = 1'b1;
   endtask

   task automatic ss_off();
      @(negedge clk);
      ss = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic expect_wr(input logic [2:0] r, input logic [4:0] c,
                            input logic [23:0] d);
      exp_q.push_back('{r, c, d, 1'b1});
   endtask

   task automatic pulse_ready();
      @(negedge clk);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
   endtask

   task automatic drain_writes(input string tag);
      wr_t e, o;
      repeat (3) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rd_idx < obs_q.size()) begin
            o = obs_q[rd_idx];
            rd_idx++;
            chk({tag, "_row"}, 32'(o.row), 32'(e.row));
            chk({tag, "_col"}, 32'(o.col), 32'(e.col));
            chk({tag, "_data"}, 32'(o.data), 32'(e.data));
            chk({tag, "_lat"}, 32'(o.lat), 32'(e.lat));
         end else begin
            chk({tag, "_missing"}, 32'(obs_q.size()), 32'(rd_idx + 1));
         end
      end
      chk({tag, "_nwr"}, 32'(obs_q.size()), 32'(rd_idx));
      rd_idx = obs_q.size();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_wen", 32'(wen), 0);
      chk("rst_loaded", 32'(loaded), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err_count), 0);
      chk("rst_wdata", 32'(wdata), 0);
      chk("rst_wrow", 32'(wrow), 0);
      chk("rst_wcol", 32'(wcol), 0);
      rst = 1'b0;

      ss_on();
      send(8'hF2);
      chk("busy_pix", 32'(busy), 1);
      expect_wr(3'd2, 5'd0, 24'h010203);
      expect_wr(3'd2, 5'd1, 24'h040506);
      for (int i = 1; i <= 6; i++) send(8'(i));
      ss_off();
      drain_writes("basic");
      chk("basic_err", 32'(err_count), 0);
      chk("basic_busy", 32'(busy), 0);

      ss_on();
      send(8'h20); send(8'h05); send(8'h1F);
      expect_wr(3'd5, 5'd31, 24'hAABBCC);
      expect_wr(3'd6, 5'd0, 24'hDDEEFF);
      send(8'hAA); send(8'hBB); send(8'hCC);
      send(8'hDD); send(8'hEE); send(8'hFF);
      ss_off();
      drain_writes("hdr_wrap");

      ss_on(); send(8'h10); ss_off();
      chk("commit1_loaded", 32'(loaded_cnt), 1);
      ss_on();
      send(8'hF0); send(8'h11); send(8'h22); send(8'h33);
      ss_off();
      drain_writes("held");
      pulse_ready();
      ss_on();
      expect_wr(3'd0, 5'd0, 24'h445566);
      send(8'hF0); send(8'h44); send(8'h55); send(8'h66);
      ss_off();
      drain_writes("released");

      ss_on(); send(8'h10); ss_off();
      chk("commit2_loaded", 32'(loaded_cnt), 2);
      ss_on(); send(8'h10); ss_off();
      chk("commit3_noload", 32'(loaded_cnt), 2);
      ss_on(); send(8'h10);
      @(negedge clk);
      ss = 1'b0;
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("coinc_noload", 32'(loaded_cnt), 2);
      ss_on();
      send(8'hF1); send(8'h01); send(8'h02); send(8'h03);
      ss_off();
      drain_writes("coinc_held");
      ss_on(); send(8'h11); ss_off();
      ss_on();
      expect_wr(3'd3, 5'd0, 24'h0A0B0C);
      send(8'hF3); send(8'h0A); send(8'h0B); send(8'h0C);
      ss_off();
      drain_writes("unhold");

      ss_on(); send(8'h55); ss_off();
      ss_on(); send(8'hF9); ss_off();
      ss_on(); send(8'hF0); send(8'h01); send(8'h02); ss_off();
      chk("err_cnt", 32'(err_count), 3);
      drain_writes("err_nowr");

      ss_on();
      send(8'hF3); send(8'h01); send(8'h02);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_err", 32'(err_count), 0);
      chk("mid_rst_wdata", 32'(wdata), 0);
      chk("mid_rst_wen", 32'(wen), 0);
      rst = 1'b0;
      ss = 1'b0;
      repeat (2) @(negedge clk);
      ss_on();
      expect_wr(3'd1, 5'd0, 24'h070809);
      send(8'hF1); send(8'h07); send(8'h08); send(8'h09);
      ss_off();
      drain_writes("post_rst");
      chk("post_rst_err", 32'(err_count), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
